// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared constants for the multi-cycle MIPS main control FSM.
//   - opcode values decoded by the controller
//   - 4-bit state encodings (also visible on the state_o debug port)
//   - ALU op, ALU B source and PC source select encodings
//   - ctrl_t bundle of per-cycle datapath controls and a memory-state helper
package mips_ctrl_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // State encodings
    localparam logic [3:0] RESET  = 4'd0;
    localparam logic [3:0] FETCH  = 4'd1;
    localparam logic [3:0] DECODE = 4'd2;
    localparam logic [3:0] MEMADR = 4'd3;
    localparam logic [3:0] MEMRD  = 4'd4;
    localparam logic [3:0] MEMWB  = 4'd5;
    localparam logic [3:0] MEMWR  = 4'd6;
    localparam logic [3:0] EXEC   = 4'd7;
    localparam logic [3:0] ALUWB  = 4'd8;
    localparam logic [3:0] BRANCH = 4'd9;
    localparam logic [3:0] ADDIEX = 4'd10;
    localparam logic [3:0] ADDIWB = 4'd11;
    localparam logic [3:0] JUMP   = 4'd12;
    localparam logic [3:0] FAULT  = 4'd13;
    localparam logic [3:0] TRAP   = 4'd14;

    // ALU operation
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand source
    localparam logic [1:0] ALUSRCB_RT      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SL2 = 2'b11;

    // Next-PC source
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       instr_done;
    } ctrl_t;

    // States that wait on the memory handshake
    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting on mem_ready inside a memory
// state and flags a timeout.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_mem      : the FSM is currently in a memory state
//   mem_ready   : memory completed its access this cycle
//   timeout     : count has reached MEM_TIMEOUT and memory is still not ready
// The count is cleared whenever the FSM is outside a memory state or the
// access completes, so every memory state is entered with a count of 0.
// MEM_TIMEOUT = 0 removes the counter entirely. TMR_W must be wide enough to
// hold MEM_TIMEOUT itself.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMR_W       = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_mem,
    input  logic mem_ready,
    output logic timeout
);

    generate
        if (MEM_TIMEOUT == 0) begin : g_no_timer
            assign timeout = 1'b0;
        end else begin : g_timer
            logic [TMR_W-1:0] count_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else if (!in_mem || mem_ready) begin
                    count_reg <= '0;
                end else if (count_reg != {TMR_W{1'b1}}) begin
                    count_reg <= count_reg + TMR_W'(1);
                end
            end

            // A ready in the same cycle the limit is reached wins over the timeout.
            assign timeout = in_mem && !mem_ready &&
                             (count_reg == TMR_W'(MEM_TIMEOUT));
        end
    endgenerate

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore main-control FSM for the multi-cycle MIPS core.
// Sequences fetch / decode / execute / memory / writeback and drives the
// datapath selects and write enables each cycle; memory states stall on
// mem_ready and fall into FAULT if memory hangs longer than MEM_TIMEOUT.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   op                    opcode from the instruction register
//   mem_ready             memory access completed this cycle
//   pcwrite, branch       PC write (unconditional / zero-qualified)
//   iord                  memory address select (0=PC, 1=ALUOut)
//   memread, memwrite     memory requests
//   irwrite               instruction register load
//   memtoreg, regdst      register write data / destination selects
//   regwrite              register file write enable
//   alusrca, alusrcb      ALU operand selects
//   aluop, pcsrc          ALU operation, next-PC source
//   instr_done            pulse in an instruction's final cycle
//   mem_err               memory timeout flag (held until reset)
//   illegal_op            unknown opcode trap flag (only with ILLEGAL_OP_TRAP_EN)
//   state_o               current state encoding, debug only
//
// Build option: define ILLEGAL_OP_TRAP_EN to trap unknown opcodes in TRAP
// instead of silently returning to FETCH.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int TMR_W       = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               pcwrite,
    output logic               branch,
    output logic               iord,
    output logic               memread,
    output logic               memwrite,
    output logic               irwrite,
    output logic               memtoreg,
    output logic               regdst,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [ALUOP_W-1:0] aluop,
    output logic [1:0]         pcsrc,
    output logic               instr_done,
    output logic               mem_err,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic               illegal_op,
`endif
    output logic [3:0]         state_o
);

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic       timeout;
    ctrl_t      ctrl;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMR_W       (TMR_W)
    ) u_mem_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_mem    (is_mem_state(state_reg)),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    // Async reset makes every strobe drop the moment rst_n falls, so a
    // write in progress cannot complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RESET:  state_next = FETCH;
            FETCH: begin
                if (timeout)        state_next = FAULT;
                else if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                case (op)
                    OP_W'(OP_LW),
                    OP_W'(OP_SW):    state_next = MEMADR;
                    OP_W'(OP_RTYPE): state_next = EXEC;
                    OP_W'(OP_BEQ):   state_next = BRANCH;
                    OP_W'(OP_ADDI):  state_next = ADDIEX;
                    OP_W'(OP_J):     state_next = JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:         state_next = TRAP;
`else
                    default:         state_next = FETCH;
`endif
                endcase
            end
            // op is looked at again here; the IR is not reloaded until FETCH.
            MEMADR: begin
                if (op == OP_W'(OP_LW))      state_next = MEMRD;
                else if (op == OP_W'(OP_SW)) state_next = MEMWR;
                else                         state_next = FETCH;
            end
            MEMRD: begin
                if (timeout)        state_next = FAULT;
                else if (mem_ready) state_next = MEMWB;
            end
            MEMWB:  state_next = FETCH;
            MEMWR: begin
                if (timeout)        state_next = FAULT;
                else if (mem_ready) state_next = FETCH;
            end
            EXEC:   state_next = ALUWB;
            ALUWB:  state_next = FETCH;
            BRANCH: state_next = FETCH;
            ADDIEX: state_next = ADDIWB;
            ADDIWB: state_next = FETCH;
            JUMP:   state_next = FETCH;
            FAULT:  state_next = FAULT;
`ifdef ILLEGAL_OP_TRAP_EN
            TRAP:   state_next = TRAP;
`endif
            // Unused encodings recover through RESET.
            default: state_next = RESET;
        endcase
    end

    // Control decode of the current state. FETCH and MEMWR also qualify
    // their final-cycle strobes with mem_ready.
    always_comb begin
        ctrl = '0;
        case (state_reg)
            FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = ALUSRCB_FOUR;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            DECODE: begin
                ctrl.alusrcb = ALUSRCB_IMM_SL2;
            end
            MEMADR, ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
            end
            MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            MEMWB: begin
                ctrl.memtoreg   = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEMWR: begin
                ctrl.memwrite   = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.regdst     = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alusrca    = 1'b1;
                ctrl.aluop      = ALUOP_SUB;
                ctrl.pcsrc      = PCSRC_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ADDIWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            JUMP: begin
                ctrl.pcsrc      = PCSRC_JUMP;
                ctrl.pcwrite    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign pcwrite    = ctrl.pcwrite;
    assign branch     = ctrl.branch;
    assign iord       = ctrl.iord;
    assign memread    = ctrl.memread;
    assign memwrite   = ctrl.memwrite;
    assign irwrite    = ctrl.irwrite;
    assign memtoreg   = ctrl.memtoreg;
    assign regdst     = ctrl.regdst;
    assign regwrite   = ctrl.regwrite;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign aluop      = ALUOP_W'(ctrl.aluop);
    assign pcsrc      = ctrl.pcsrc;
    assign instr_done = ctrl.instr_done;
    // FAULT and TRAP are only left through reset, so decoding them is sticky.
    assign mem_err    = (state_reg == FAULT);
`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal_op = (state_reg == TRAP);
`endif
    assign state_o    = state_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: scoreboard bench for mips_multicycle_ctrl.
// Each driven cycle pushes the expected state and control vector; a monitor
// pops and compares them just after the following falling edge.
// Honours ILLEGAL_OP_TRAP_EN the same way as the design.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    localparam int OP_W        = 6;
    localparam int ALUOP_W     = 2;
    localparam int MEM_TIMEOUT = 4;
    localparam int TMR_W       = 5;

    // Expected control vectors, field order:
    // pcwrite branch iord memread memwrite irwrite memtoreg regdst regwrite
    // alusrca alusrcb[2] aluop[2] pcsrc[2] instr_done mem_err
    localparam logic [17:0] V_ZERO   = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] V_F_WAIT = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] V_F_RDY  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] V_DEC    = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] V_ADR    = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] V_MRD    = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] V_MWB    = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
    localparam logic [17:0] V_MWR_W  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] V_MWR_D  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [17:0] V_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] V_ALUWB  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
    localparam logic [17:0] V_BRANCH = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [17:0] V_ADDIWB = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
    localparam logic [17:0] V_JUMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
    localparam logic [17:0] V_FAULT  = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

    localparam logic [5:0] OP_BAD = 6'b111111;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_ready = 1'b0;
    logic [OP_W-1:0]   op = '0;
    logic              pcwrite, branch, iord, memread, memwrite, irwrite;
    logic              memtoreg, regdst, regwrite, alusrca, instr_done, mem_err;
    logic [1:0]        alusrcb, pcsrc;
    logic [ALUOP_W-1:0] aluop;
    logic [3:0]        state_o;
`ifdef ILLEGAL_OP_TRAP_EN
    logic              illegal_op;
`endif
    logic [17:0]       got_ctrl;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [17:0] ctrl;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(
        .OP_W        (OP_W),
        .ALUOP_W     (ALUOP_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMR_W       (TMR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .mem_ready  (mem_ready),
        .pcwrite    (pcwrite),
        .branch     (branch),
        .iord       (iord),
        .memread    (memread),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .aluop      (aluop),
        .pcsrc      (pcsrc),
        .instr_done (instr_done),
        .mem_err    (mem_err),
`ifdef ILLEGAL_OP_TRAP_EN
        .illegal_op (illegal_op),
`endif
        .state_o    (state_o)
    );

    assign got_ctrl = {pcwrite, branch, iord, memread, memwrite, irwrite,
                       memtoreg, regdst, regwrite, alusrca, alusrcb,
                       aluop, pcsrc, instr_done, mem_err};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, req);
        end
    endtask

    // Drive one cycle's inputs on the falling edge and record what the DUT
    // must show during that cycle.
    task automatic step(input logic rst, input logic rdy, input logic [5:0] o,
                        input logic [3:0] st, input logic [17:0] v,
                        input string tag);
        exp_t e;
        @(negedge clk);
        rst_n     = rst;
        mem_ready = rdy;
        op        = o;
        e.tag  = tag;
        e.st   = st;
        e.ctrl = v;
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check({e.tag, "_state"}, 32'(state_o), 32'(e.st));
                check({e.tag, "_ctrl"}, 32'(got_ctrl), 32'(e.ctrl));
                $display("txn %-10s state=%0d ctrl=%b", e.tag, state_o, got_ctrl);
            end
        end
    end

    initial begin : driver
        // Reset state
        step(0, 0, OP_RTYPE, RESET, V_ZERO, "rst0");
        step(0, 0, OP_RTYPE, RESET, V_ZERO, "rst1");

        // lw, ready throughout: 5 cycles
        step(1, 1, OP_LW, RESET,  V_ZERO, "rel0");
        step(1, 1, OP_LW, FETCH,  V_F_RDY, "lw_f");
        step(1, 1, OP_LW, DECODE, V_DEC,   "lw_d");
        step(1, 1, OP_LW, MEMADR, V_ADR,   "lw_a");
        step(1, 1, OP_LW, MEMRD,  V_MRD,   "lw_r");
        step(1, 1, OP_LW, MEMWB,  V_MWB,   "lw_wb");

        // beq and j: 3 cycles each
        step(1, 1, OP_BEQ, FETCH,  V_F_RDY,  "beq_f");
        step(1, 1, OP_BEQ, DECODE, V_DEC,    "beq_d");
        step(1, 1, OP_BEQ, BRANCH, V_BRANCH, "beq_b");
        step(1, 1, OP_J,   FETCH,  V_F_RDY,  "j_f");
        step(1, 1, OP_J,   DECODE, V_DEC,    "j_d");
        step(1, 1, OP_J,   JUMP,   V_JUMP,   "j_j");

        // R-type and addi: 4 cycles each
        step(1, 1, OP_RTYPE, FETCH,  V_F_RDY, "r_f");
        step(1, 1, OP_RTYPE, DECODE, V_DEC,   "r_d");
        step(1, 1, OP_RTYPE, EXEC,   V_EXEC,  "r_x");
        step(1, 1, OP_RTYPE, ALUWB,  V_ALUWB, "r_wb");
        step(1, 1, OP_ADDI,  FETCH,  V_F_RDY, "ai_f");
        step(1, 1, OP_ADDI,  DECODE, V_DEC,   "ai_d");
        step(1, 1, OP_ADDI,  ADDIEX, V_ADR,   "ai_x");
        step(1, 1, OP_ADDI,  ADDIWB, V_ADDIWB, "ai_wb");

        // sw with memory stalled three cycles in MEMWR
        step(1, 1, OP_SW, FETCH,  V_F_RDY, "sw_f");
        step(1, 1, OP_SW, DECODE, V_DEC,   "sw_d");
        step(1, 1, OP_SW, MEMADR, V_ADR,   "sw_a");
        for (int i = 0; i < 3; i++) step(1, 0, OP_SW, MEMWR, V_MWR_W, "sw_wait");
        step(1, 1, OP_SW, MEMWR, V_MWR_D, "sw_done");

        // Ready arriving exactly when the wait count hits the limit wins
        for (int i = 0; i < MEM_TIMEOUT; i++)
            step(1, 0, OP_RTYPE, FETCH, V_F_WAIT, "edge_wait");
        step(1, 1, OP_RTYPE, FETCH,  V_F_RDY, "edge_rdy");
        step(1, 1, OP_RTYPE, DECODE, V_DEC,   "edge_d");
        step(1, 1, OP_RTYPE, EXEC,   V_EXEC,  "edge_x");
        step(1, 1, OP_RTYPE, ALUWB,  V_ALUWB, "edge_wb");

        // Reset pulled mid-MEMWB kills regwrite immediately
        step(1, 1, OP_LW, FETCH,  V_F_RDY, "lw2_f");
        step(1, 1, OP_LW, DECODE, V_DEC,   "lw2_d");
        step(1, 1, OP_LW, MEMADR, V_ADR,   "lw2_a");
        step(1, 1, OP_LW, MEMRD,  V_MRD,   "lw2_r");
        step(1, 1, OP_LW, MEMWB,  V_MWB,   "lw2_wb");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_regwrite", 32'(regwrite), 32'd0);
        check("async_rst_state", 32'(state_o), 32'(RESET));
        step(1, 1, OP_RTYPE, RESET,  V_ZERO,  "rel1");
        step(1, 1, OP_RTYPE, FETCH,  V_F_RDY, "r2_f");
        step(1, 1, OP_RTYPE, DECODE, V_DEC,   "r2_d");
        step(1, 1, OP_RTYPE, EXEC,   V_EXEC,  "r2_x");
        step(1, 1, OP_RTYPE, ALUWB,  V_ALUWB, "r2_wb");

        // Unknown opcode
        step(1, 1, OP_BAD, FETCH,  V_F_RDY, "bad_f");
        step(1, 1, OP_BAD, DECODE, V_DEC,   "bad_d");
`ifdef ILLEGAL_OP_TRAP_EN
        step(1, 1, OP_BAD, TRAP, V_ZERO, "trap0");
        #2;
        check("illegal_op_set", 32'(illegal_op), 32'd1);
        step(1, 1, OP_BAD, TRAP, V_ZERO, "trap1");
`else
        step(1, 0, OP_BAD, FETCH, V_F_WAIT, "nop_f");
`endif
        step(0, 0, OP_RTYPE, RESET, V_ZERO, "rst2");
`ifdef ILLEGAL_OP_TRAP_EN
        #2;
        check("illegal_op_clr", 32'(illegal_op), 32'd0);
`endif

        // Hung memory in FETCH: MEM_TIMEOUT wait cycles, then the limit cycle
        step(1, 0, OP_RTYPE, RESET, V_ZERO, "rel2");
        for (int i = 0; i <= MEM_TIMEOUT; i++)
            step(1, 0, OP_RTYPE, FETCH, V_F_WAIT, "to_wait");
        for (int i = 0; i < 3; i++)
            step(1, 1, OP_RTYPE, FAULT, V_FAULT, "fault");
        step(0, 0, OP_RTYPE, RESET, V_ZERO, "rst3");

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
